// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data memory between the pipeline MEM stage and a
// host access port. While the host owns the memory the pipeline is stalled for exactly
// four cycles (DRAIN, HOST_ACC, HOST_RD, ACK). After each host access the pipeline is
// guaranteed PIPE_QUANTUM un-stalled cycles before the host can be granted again.
// Optional statistics counters are built only when DMEM_ARB_STATS_EN is defined;
// otherwise stat_host_cnt / stat_stall_cnt are tied to zero.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 64,
  parameter int PIPE_QUANTUM = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_we,
  input  logic [ADDR_WIDTH-1:0] pipe_waddr,
  input  logic [DATA_WIDTH-1:0] pipe_wdata,
  input  logic [ADDR_WIDTH-1:0] pipe_raddr,
  output logic [DATA_WIDTH-1:0] pipe_rdata,
  output logic                  pipe_stall,
  input  logic                  host_req,
  input  logic                  host_wr,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_waddr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [ADDR_WIDTH-1:0] dmem_raddr,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [15:0]           stat_host_cnt,
  output logic [31:0]           stat_stall_cnt
);

  typedef enum logic [2:0] {
    ST_PIPE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_HOST_ACC = 3'd2,
    ST_HOST_RD  = 3'd3,
    ST_ACK      = 3'd4
  } state_t;

  localparam logic [7:0] QUANTUM = 8'(PIPE_QUANTUM);

  state_t                state_reg, state_next;
  logic [7:0]            qcnt_reg, qcnt_next;
  logic [DATA_WIDTH-1:0] host_rdata_reg;
  logic                  we_sel;

  // State, quantum counter and captured host read data
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_PIPE;
      qcnt_reg       <= 8'd0;
      host_rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      qcnt_reg  <= qcnt_next;
      // dmem_rdata in HOST_RD is the read issued in HOST_ACC, which already sees the host write
      if (state_reg == ST_HOST_RD) begin
        host_rdata_reg <= dmem_rdata;
      end
    end
  end

  // Next-state logic and state-decoded memory port steering
  always_comb begin
    state_next = state_reg;
    qcnt_next  = qcnt_reg;
    pipe_stall = 1'b1;
    host_ack   = 1'b0;
    we_sel     = pipe_we;
    dmem_waddr = pipe_waddr;
    dmem_wdata = pipe_wdata;
    dmem_raddr = pipe_raddr;
    case (state_reg)
      ST_PIPE: begin
        pipe_stall = 1'b0;
        if (qcnt_reg != 8'd0) begin
          qcnt_next = qcnt_reg - 8'd1;
        end
        // Grant once the counter reaches zero at the end of this cycle, so the
        // pipeline gets exactly PIPE_QUANTUM un-stalled cycles between accesses.
        if (host_req && (qcnt_reg <= 8'd1)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Ports stay with the pipeline so the in-flight MEM op completes
        state_next = ST_HOST_ACC;
      end
      ST_HOST_ACC: begin
        we_sel     = host_wr;
        dmem_waddr = host_addr;
        dmem_wdata = host_wdata;
        dmem_raddr = host_addr;
        state_next = ST_HOST_RD;
      end
      ST_HOST_RD: begin
        we_sel     = 1'b0;
        dmem_waddr = host_addr;
        dmem_wdata = host_wdata;
        dmem_raddr = host_addr;
        state_next = ST_ACK;
      end
      ST_ACK: begin
        // Read the pipeline address again so pipe_rdata is valid on unstall
        we_sel     = 1'b0;
        host_ack   = 1'b1;
        qcnt_next  = QUANTUM;
        state_next = ST_PIPE;
      end
      default: begin
        state_next = ST_PIPE;
      end
    endcase
  end

  assign dmem_we    = we_sel & reset;
  assign pipe_rdata = dmem_rdata;
  assign host_rdata = host_rdata_reg;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] host_cnt_reg;
  logic [31:0] stall_cnt_reg;

  // Completed host accesses and stalled cycles, both free-running with wrap
  always_ff @(posedge clk) begin
    if (!reset) begin
      host_cnt_reg  <= 16'd0;
      stall_cnt_reg <= 32'd0;
    end else begin
      if (host_ack) begin
        host_cnt_reg <= host_cnt_reg + 16'd1;
      end
      if (pipe_stall) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign stat_host_cnt  = host_cnt_reg;
  assign stat_stall_cnt = stall_cnt_reg;
`else
  assign stat_host_cnt  = 16'd0;
  assign stat_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios with literal expectations followed by
// randomized pipeline/host traffic checked every cycle against a timeline model
// (grant cycle, stall window, ack cycle, earliest next grant) and a shadow memory.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int Q  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pipe_we;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic [AW-1:0] pipe_raddr;
  logic [DW-1:0] pipe_rdata;
  logic          pipe_stall;
  logic          host_req;
  logic          host_wr;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          dmem_we;
  logic [AW-1:0] dmem_waddr;
  logic [DW-1:0] dmem_wdata;
  logic [AW-1:0] dmem_raddr;
  logic [DW-1:0] dmem_rdata;
  logic [15:0]   stat_host_cnt;
  logic [31:0]   stat_stall_cnt;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPE_QUANTUM(Q)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .pipe_raddr(pipe_raddr), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
    .stat_host_cnt(stat_host_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Data memory the DUT drives: write port A, read port B, write-first on collision
  logic [DW-1:0] env_mem [256];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= '0;
    end else if (dmem_we) begin
      env_mem[dmem_waddr] <= dmem_wdata;
    end
    dmem_rdata <= (dmem_we && reset && dmem_waddr == dmem_raddr) ? dmem_wdata : env_mem[dmem_raddr];
  end

  // ---------------- reference model ----------------
  // An access granted in cycle g stalls cycles g+1..g+4 and acks in g+4;
  // the next grant may not happen before cycle g+4+Q.
  logic [DW-1:0] ref_mem [256];
  int            m_cyc = 0;
  int            m_g = -1;
  int            m_earliest = 0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] m_hrd = '0;
  logic [15:0]   m_hcnt = '0;
  logic [31:0]   m_scnt = '0;

  always @(negedge clk) begin : model
    int            k;
    logic          e_stall, e_ack, e_we;
    logic [AW-1:0] e_waddr, e_raddr;
    logic [DW-1:0] e_wdata, old_rdata;
    logic [15:0]   e_hcnt;
    logic [31:0]   e_scnt;
    k       = (m_g >= 0) ? (m_cyc - m_g) : 0;
    e_stall = (k != 0);
    e_ack   = (k == 4);
    e_we    = pipe_we;
    e_waddr = pipe_waddr;
    e_wdata = pipe_wdata;
    e_raddr = pipe_raddr;
    if (k == 2) begin
      e_we = host_wr; e_waddr = host_addr; e_wdata = host_wdata; e_raddr = host_addr;
    end else if (k == 3) begin
      e_we = 1'b0; e_raddr = host_addr;
    end else if (k == 4) begin
      e_we = 1'b0;
    end
`ifdef DMEM_ARB_STATS_EN
    e_hcnt = m_hcnt; e_scnt = m_scnt;
`else
    e_hcnt = 16'd0; e_scnt = 32'd0;
`endif
    if (!reset) begin
      chk("rst_dmem_we", dmem_we, 0);
      m_rdata = ref_mem[e_raddr];
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      m_g = -1; m_earliest = m_cyc + 1;
      m_hrd = '0; m_hcnt = '0; m_scnt = '0;
    end else begin
      chk("m_stall", pipe_stall, e_stall);
      chk("m_ack", host_ack, e_ack);
      chk("m_we", dmem_we, e_we);
      if (e_we) begin
        chk("m_waddr", dmem_waddr, e_waddr);
        chk("m_wdata", dmem_wdata, e_wdata);
      end
      chk("m_raddr", dmem_raddr, e_raddr);
      chk("m_pipe_rdata", pipe_rdata, m_rdata);
      chk("m_host_rdata", host_rdata, m_hrd);
      chk("m_stat_host", stat_host_cnt, e_hcnt);
      chk("m_stat_stall", stat_stall_cnt, e_scnt);
      old_rdata = m_rdata;
      if (e_we) ref_mem[e_waddr] = e_wdata;
      m_rdata = ref_mem[e_raddr];
      if (k == 3) m_hrd = old_rdata;
      if (e_stall) m_scnt = m_scnt + 32'd1;
      if (e_ack) m_hcnt = m_hcnt + 16'd1;
      if (k == 0 && host_req && m_cyc >= m_earliest) m_g = m_cyc;
      else if (k == 4) begin
        m_g = -1;
        m_earliest = m_cyc + Q;
      end
    end
    m_cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One host access from a fresh request; reports ack cycle offset and stall count
  task automatic host_access(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             output int ack_k, output int stall_n);
    step();
    host_req = 1'b1; host_wr = wr; host_addr = addr; host_wdata = data;
    ack_k = -1; stall_n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (pipe_stall) stall_n++;
      if (host_ack) begin
        ack_k = k;
        break;
      end
    end
    step();
    host_req = 1'b0;
  endtask

  initial begin : main
    int ack_k, stall_n, first, second, wait_cnt;
    reset = 1'b0; pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0; pipe_raddr = '0;
    host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
    idle(3);
    reset = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_stall", pipe_stall, 0);
    chk("reset_ack", host_ack, 0);
    chk("reset_host_rdata", host_rdata, 0);
    chk("reset_stat_host", stat_host_cnt, 0);
    chk("reset_stat_stall", stat_stall_cnt, 0);

    // Pipeline write with idle host goes straight through
    step();
    pipe_we = 1'b1; pipe_waddr = 8'h10; pipe_wdata = 64'hA5;
    @(negedge clk);
    chk("pipe_wr_we", dmem_we, 1);
    chk("pipe_wr_waddr", dmem_waddr, 64'h10);
    chk("pipe_wr_wdata", dmem_wdata, 64'hA5);
    chk("pipe_wr_stall", pipe_stall, 0);
    step();
    pipe_waddr = 8'h05; pipe_wdata = 64'h55AA;
    step();
    pipe_we = 1'b0; pipe_raddr = 8'h05;
    idle(6);

    // Host write
    host_access(1'b1, 8'h20, 64'h1234, ack_k, stall_n);
    chk("hwr_ack_cycle", ack_k, 4);
    chk("hwr_stall_cycles", stall_n, 4);
    chk("hwr_host_rdata", host_rdata, 64'h1234);
    chk("hwr_mem", env_mem[8'h20], 64'h1234);
    idle(6);

    // Host read while pipeline reads 0x05
    host_access(1'b0, 8'h20, 64'h0, ack_k, stall_n);
    @(negedge clk);
    chk("hrd_host_rdata", host_rdata, 64'h1234);
    chk("hrd_pipe_rdata", pipe_rdata, 64'h55AA);
    idle(6);

    // Request held high: acks spaced Q+4 cycles
    step();
    host_req = 1'b1; host_wr = 1'b0; host_addr = 8'h03;
    first = -1; second = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (host_ack) begin
        if (first < 0) first = c;
        else begin
          second = c;
          break;
        end
      end
    end
    chk("held_ack_spacing", second - first, Q + 4);
    step();
    host_req = 1'b0;
    idle(6);

    // Reset in HOST_ACC aborts the access
    step();
    host_req = 1'b1; host_wr = 1'b1; host_addr = 8'h30; host_wdata = 64'hBEEF;
    step();
    step();
    reset = 1'b0; host_req = 1'b0;
    @(negedge clk);
    chk("abort_we", dmem_we, 0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_stall", pipe_stall, 0);
    chk("abort_ack", host_ack, 0);
    chk("abort_host_rdata", host_rdata, 0);
    chk("abort_stat_host", stat_host_cnt, 0);
    chk("abort_stat_stall", stat_stall_cnt, 0);

    // Three accesses; the first is granted at once (quantum counter cleared)
    host_access(1'b1, 8'h40, 64'h77, ack_k, stall_n);
    chk("post_rst_ack_cycle", ack_k, 4);
    idle(6);
    host_access(1'b0, 8'h40, 64'h0, ack_k, stall_n);
    idle(6);
    host_access(1'b1, 8'h41, 64'h88, ack_k, stall_n);
    @(negedge clk);
`ifdef DMEM_ARB_STATS_EN
    chk("stats_host_cnt", stat_host_cnt, 3);
    chk("stats_stall_cnt", stat_stall_cnt, 12);
`else
    chk("stats_host_cnt", stat_host_cnt, 0);
    chk("stats_stall_cnt", stat_stall_cnt, 0);
`endif

    // Random traffic
    wait_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      reset = 1'b1;
      pipe_we = 1'($urandom);
      pipe_waddr = 8'($urandom_range(0, 15));
      pipe_wdata = {$urandom, $urandom};
      pipe_raddr = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        host_req = 1'b0;
        wait_cnt = 0;
      end else if (host_req && wait_cnt == 0) begin
        // previous cycle acked: either keep requesting with new params or drop
        if ($urandom_range(0, 1) == 0) begin
          host_wr = 1'($urandom); host_addr = 8'($urandom_range(0, 15));
          host_wdata = {$urandom, $urandom};
        end else begin
          host_req = 1'b0;
        end
      end else if (!host_req && $urandom_range(0, 3) == 0) begin
        host_req = 1'b1; host_wr = 1'($urandom); host_addr = 8'($urandom_range(0, 15));
        host_wdata = {$urandom, $urandom};
        wait_cnt = 1;
      end
      @(negedge clk);
      if (host_req) begin
        if (host_ack) wait_cnt = 0;
        else wait_cnt++;
        if (wait_cnt > 30) begin
          checks++;
          errors++;
          $display("FAIL rand_ack_timeout actual=no_ack required=ack_within_30");
          host_req = 1'b0;
          wait_cnt = 0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
